// File: rtl/jt12_sepn_if.sv
// Purpose : bundles the mixed-bus inputs and the per-slot and per-frame observation outputs of jt12_sepn.
// Latency : no logic here. master drives clk_en/mixed/cnt/mask/sel, slave drives the results.
// Backpressure: none. The separator samples on every clk_en and cannot stall the pipeline it watches.
// Ports   : clk_en, mixed[W], cnt[CW], mask[N], sel[CW] go master->slave.
//           slots[N*W], sel_val/alland/allor[W], frame_done, changed, frame_cnt[16], cnt_err go slave->master.
interface jt12_sepn_if #(
   parameter int W  = 10,
   parameter int N  = 24,
   parameter int CW = 5
);
   logic            clk_en;
   logic [W-1:0]    mixed;
   logic [CW-1:0]   cnt;
   logic [N-1:0]    mask;
   logic [CW-1:0]   sel;

   logic [N*W-1:0]  slots;
   logic [W-1:0]    sel_val;
   logic [W-1:0]    alland;
   logic [W-1:0]    allor;
   logic            frame_done;
   logic            changed;
   logic [15:0]     frame_cnt;
   logic            cnt_err;

   modport master (
      output clk_en, mixed, cnt, mask, sel,
      input  slots, sel_val, alland, allor, frame_done, changed, frame_cnt, cnt_err
   );

   modport slave (
      input  clk_en, mixed, cnt, mask, sel,
      output slots, sel_val, alland, allor, frame_done, changed, frame_cnt, cnt_err
   );
endinterface

// File: rtl/jt12_sepn.sv
// Purpose : splits a time-multiplexed operator bus into per-slot registers and reports per-frame
//           AND/OR over masked slots. Also provides a watched-slot change detector, a frame counter
//           and slot-counter sanity checking.
// Latency : slots update on the sampling edge. Frame results and the frame_done/changed pulses are
//           valid right after the edge that samples slot N-1.
// Backpressure: none. Every clk_en sample is consumed. A bad cnt aborts the frame and sets cnt_err.
// Ports   : clk, rst (sync, active-high), bus (jt12_sepn_if.slave).
module jt12_sepn #(
   parameter int W    = 10,
   parameter int N    = 24,
   parameter int CW   = 5,
   parameter int POS0 = 0
) (
   input  logic       clk,
   input  logic       rst,
   jt12_sepn_if.slave bus
);
   localparam logic [CW:0] NW  = (CW+1)'(N);
   localparam logic [CW:0] OFF = (CW+1)'(N - POS0);

   logic [W-1:0]  slot_q [N];
   logic [W-1:0]  acc_and, acc_or;
   logic [W-1:0]  sel_val_q, alland_q, allor_q;
   logic          armed, have_prev, prev_valid;
   logic [CW-1:0] prev_cnt;
   logic          done_q, changed_q, err_q;
   logic [15:0]   fcnt_q;

   // Slot decoding. The sum is one bit wider so that cnt + (N-POS0) cannot overflow.
   logic [CW:0]   sum;
   logic [CW-1:0] slot;
   logic          cnt_ok, brk, arm_now, last, sel_in;
   logic [CW-1:0] nxt;
   logic          mbit;
   logic [W-1:0]  a_next, o_next, sel_pick;

   always_comb begin
      sum     = {1'b0, bus.cnt} + OFF;
      slot    = CW'((sum >= NW) ? sum - NW : sum);
      cnt_ok  = ({1'b0, bus.cnt} < NW);
      sel_in  = ({1'b0, bus.sel} < NW);
      nxt     = (prev_cnt == CW'(N-1)) ? '0 : prev_cnt + CW'(1);
      brk     = have_prev && (bus.cnt != nxt);
      // A broken sequence drops the running frame, but a slot-0 sample re-arms at once.
      arm_now = (slot == '0) || (armed && !brk);
      last    = (slot == CW'(N-1));
      mbit    = bus.mask[slot];
      if (slot == '0) begin
         a_next = mbit ? bus.mixed : '1;
         o_next = mbit ? bus.mixed : '0;
      end else begin
         a_next = acc_and & (mbit ? bus.mixed : '1);
         o_next = acc_or  | (mbit ? bus.mixed : '0);
      end
      // Slot N-1 is still on the bus at completion, so it has not reached its register yet.
      sel_pick = '0;
      for (int i = 0; i < N; i++)
         if (bus.sel == CW'(i))
            sel_pick = (i == N-1) ? bus.mixed : slot_q[i];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) slot_q[i] <= '0;
         acc_and    <= '0;
         acc_or     <= '0;
         sel_val_q  <= '0;
         alland_q   <= '0;
         allor_q    <= '0;
         armed      <= 1'b0;
         have_prev  <= 1'b0;
         prev_valid <= 1'b0;
         prev_cnt   <= '0;
         done_q     <= 1'b0;
         changed_q  <= 1'b0;
         err_q      <= 1'b0;
         fcnt_q     <= '0;
      end else begin
         // Pulses last one clk regardless of clk_en.
         done_q    <= 1'b0;
         changed_q <= 1'b0;
         if (bus.clk_en) begin
            if (!cnt_ok) begin
               err_q     <= 1'b1;
               armed     <= 1'b0;
               have_prev <= 1'b0;
            end else begin
               for (int i = 0; i < N; i++)
                  if (slot == CW'(i)) slot_q[i] <= bus.mixed;
               prev_cnt  <= bus.cnt;
               have_prev <= 1'b1;
               if (brk) err_q <= 1'b1;
               armed <= arm_now;
               if (arm_now) begin
                  acc_and <= a_next;
                  acc_or  <= o_next;
               end
               if (arm_now && last) begin
                  alland_q   <= a_next;
                  allor_q    <= o_next;
                  sel_val_q  <= sel_in ? sel_pick : '0;
                  changed_q  <= prev_valid && sel_in && (sel_pick != sel_val_q);
                  prev_valid <= 1'b1;
                  done_q     <= 1'b1;
                  fcnt_q     <= fcnt_q + 16'd1;
               end
            end
         end
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_slots
      assign bus.slots[g*W +: W] = slot_q[g];
   end

   assign bus.sel_val    = sel_val_q;
   assign bus.alland     = alland_q;
   assign bus.allor      = allor_q;
   assign bus.frame_done = done_q;
   assign bus.changed    = changed_q;
   assign bus.frame_cnt  = fcnt_q;
   assign bus.cnt_err    = err_q;
endmodule

// File: tb/tb_jt12_sepn.sv
// Bench for jt12_sepn: two instances (POS0=0 and POS0=8) share one stimulus stream.
// A frame-level reference model predicts every output and is compared on each falling edge.
// Directed scenarios pin the model with hand-computed literal values.
module tb_jt12_sepn;
   localparam int W = 10, N = 24, CW = 5;
   localparam int P0 = 0, P1 = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          clk_en = 1'b0;
   logic [W-1:0]  mixed  = '0;
   logic [CW-1:0] cnt    = '0;
   logic [N-1:0]  mask   = '1;
   logic [CW-1:0] sel    = '0;

   jt12_sepn_if #(.W(W), .N(N), .CW(CW)) if0 (), if1 ();

   assign if0.clk_en = clk_en;  assign if1.clk_en = clk_en;
   assign if0.mixed  = mixed;   assign if1.mixed  = mixed;
   assign if0.cnt    = cnt;     assign if1.cnt    = cnt;
   assign if0.mask   = mask;    assign if1.mask   = mask;
   assign if0.sel    = sel;     assign if1.sel    = sel;

   jt12_sepn #(.W(W), .N(N), .CW(CW), .POS0(P0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
   jt12_sepn #(.W(W), .N(N), .CW(CW), .POS0(P1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int            pos [2] = '{P0, P1};
   logic [W-1:0]  m_slot [2][N];
   logic [W-1:0]  f_val  [2][N];
   bit            f_msk  [2][N];
   bit            m_armed [2], m_hp [2], m_pv [2];
   int            m_prev [2];
   logic [W-1:0]  e_sel [2], e_and [2], e_or [2];
   bit            e_done [2], e_chg [2], e_err [2];
   logic [15:0]   e_fc [2];

   task automatic model_step(input int k);
      int s;
      bit brk;
      logic [W-1:0] a, o, nsel;
      if (rst) begin
         for (int i = 0; i < N; i++) m_slot[k][i] = '0;
         m_armed[k] = 0; m_hp[k] = 0; m_pv[k] = 0; m_prev[k] = 0;
         e_sel[k] = '0; e_and[k] = '0; e_or[k] = '0;
         e_done[k] = 0; e_chg[k] = 0; e_err[k] = 0; e_fc[k] = '0;
      end else begin
         e_done[k] = 0;
         e_chg[k]  = 0;
         if (clk_en) begin
            if (int'(cnt) >= N) begin
               e_err[k] = 1; m_armed[k] = 0; m_hp[k] = 0;
            end else begin
               s   = (int'(cnt) + N - pos[k]) % N;
               brk = m_hp[k] && (int'(cnt) != (m_prev[k] + 1) % N);
               if (brk) begin e_err[k] = 1; m_armed[k] = 0; end
               m_slot[k][s] = mixed;
               m_hp[k] = 1;
               m_prev[k] = int'(cnt);
               if (s == 0) m_armed[k] = 1;
               if (m_armed[k]) begin
                  f_val[k][s] = mixed;
                  f_msk[k][s] = mask[s];
               end
               if (m_armed[k] && s == N-1) begin
                  a = '1; o = '0;
                  for (int i = 0; i < N; i++)
                     if (f_msk[k][i]) begin a &= f_val[k][i]; o |= f_val[k][i]; end
                  nsel = (int'(sel) < N) ? m_slot[k][int'(sel)] : '0;
                  e_chg[k]  = (int'(sel) < N) && m_pv[k] && (nsel != e_sel[k]);
                  e_sel[k]  = nsel;
                  e_and[k]  = a;
                  e_or[k]   = o;
                  m_pv[k]   = 1;
                  e_done[k] = 1;
                  e_fc[k]   = e_fc[k] + 16'd1;
               end
            end
         end
      end
   endtask

   always @(posedge clk) begin
      model_step(0);
      model_step(1);
   end

   task automatic cmp(input int k, input logic [N*W-1:0] sl, input logic [W-1:0] sv,
                      input logic [W-1:0] al, input logic [W-1:0] ao, input logic fd,
                      input logic ch, input logic [15:0] fc, input logic ce);
      logic [N*W-1:0] es;
      for (int i = 0; i < N; i++) es[i*W +: W] = m_slot[k][i];
      chk($sformatf("i%0d.slots", k), 256'(sl), 256'(es));
      chk($sformatf("i%0d.sel_val", k), 256'(sv), 256'(e_sel[k]));
      chk($sformatf("i%0d.alland", k), 256'(al), 256'(e_and[k]));
      chk($sformatf("i%0d.allor", k), 256'(ao), 256'(e_or[k]));
      chk($sformatf("i%0d.frame_done", k), 256'(fd), 256'(e_done[k]));
      chk($sformatf("i%0d.changed", k), 256'(ch), 256'(e_chg[k]));
      chk($sformatf("i%0d.frame_cnt", k), 256'(fc), 256'(e_fc[k]));
      chk($sformatf("i%0d.cnt_err", k), 256'(ce), 256'(e_err[k]));
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         cmp(0, if0.slots, if0.sel_val, if0.alland, if0.allor, if0.frame_done,
             if0.changed, if0.frame_cnt, if0.cnt_err);
         cmp(1, if1.slots, if1.sel_val, if1.alland, if1.allor, if1.frame_done,
             if1.changed, if1.frame_cnt, if1.cnt_err);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int c, input int m, input logic en);
      cnt    = CW'(c);
      mixed  = W'(m);
      clk_en = en;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(0, 0, 1'b0);
      rst = 1'b0;
   endtask

   // Scenario 1 stream (optionally with clk_en toggling): reset lands on cnt=5.
   task automatic scen1(input bit toggle);
      for (int c = 0; c < 24; c++) begin
         if (c == 5) rst = 1'b1;
         step(c, c*3, 1'b1);
         rst = 1'b0;
         if (toggle) step(c, c*3, 1'b0);
      end
      for (int c = 0; c < 24; c++) begin
         step(c, c*3, 1'b1);
         if (c == 23) begin
            chk("s1.frame_done", 256'(if0.frame_done), 256'(1));
            chk("s1.alland", 256'(if0.alland), 256'(0));
            // OR of 0,3,...,69: 63 gives 0x3F and 66 adds bit 6.
            chk("s1.allor", 256'(if0.allor), 256'(10'h07F));
            chk("s1.frame_cnt", 256'(if0.frame_cnt), 256'(1));
         end
         if (toggle) step(c, c*3, 1'b0);
         if (toggle && c == 23) chk("s6.pulse_drop", 256'(if0.frame_done), 256'(0));
      end
   endtask

   initial begin
      int cur;
      // Reset state
      rst = 1'b1;
      step(0, 0, 1'b0);
      chk_on = 1'b1;
      step(0, 0, 1'b0);
      chk("rst.frame_cnt", 256'(if0.frame_cnt), 256'(0));
      chk("rst.slots", 256'(if0.slots), 256'(0));
      chk("rst.cnt_err", 256'(if1.cnt_err), 256'(0));
      rst = 1'b0;
      mask = '1;
      sel  = '0;

      scen1(1'b0);

      // Scenario 2: all slots but 0 masked in; then nothing masked in.
      mask = ~24'b1;
      for (int c = 0; c < 24; c++) step(c, (c == 0) ? 0 : 10'h3FF, 1'b1);
      chk("s2.alland", 256'(if0.alland), 256'(10'h3FF));
      chk("s2.allor", 256'(if0.allor), 256'(10'h3FF));
      mask = '0;
      for (int c = 0; c < 24; c++) step(c, int'($urandom_range(0, 1023)), 1'b1);
      chk("s2.alland_m0", 256'(if0.alland), 256'(10'h3FF));
      chk("s2.allor_m0", 256'(if0.allor), 256'(0));

      // Scenario 3: mixed=cnt, watch slot 16 on both offsets.
      mask = '1;
      sel  = 5'd16;
      for (int f = 0; f < 2; f++)
         for (int c = 0; c < 24; c++) step(c, c, 1'b1);
      chk("s3.p8.slot0", 256'(if1.slots[0*W +: W]), 256'(8));
      chk("s3.p8.slot15", 256'(if1.slots[15*W +: W]), 256'(23));
      chk("s3.p8.slot16", 256'(if1.slots[16*W +: W]), 256'(0));
      chk("s3.p8.sel_val", 256'(if1.sel_val), 256'(0));
      chk("s3.p0.sel_val", 256'(if0.sel_val), 256'(16));

      // Scenario 4: change detector on slot 3.
      do_reset();
      sel = 5'd3;
      for (int f = 0; f < 3; f++) begin
         for (int c = 0; c < 24; c++)
            step(c, (c == 3) ? ((f < 2) ? 'h10 : 'h11) : int'($urandom_range(0, 1023)), 1'b1);
         chk($sformatf("s4.done%0d", f), 256'(if0.frame_done), 256'(1));
         chk($sformatf("s4.changed%0d", f), 256'(if0.changed), 256'((f == 2) ? 1 : 0));
      end
      chk("s4.sel_val", 256'(if0.sel_val), 256'(10'h011));

      // Scenario 5: cnt skips 10 -> 12.
      for (int c = 0; c < 24; c++) if (c != 11) step(c, c, 1'b1);
      chk("s5.no_done", 256'(if0.frame_done), 256'(0));
      chk("s5.cnt_err", 256'(if0.cnt_err), 256'(1));
      chk("s5.fc_hold", 256'(if0.frame_cnt), 256'(3));
      for (int c = 0; c < 24; c++) step(c, c, 1'b1);
      chk("s5.done_next", 256'(if0.frame_done), 256'(1));
      chk("s5.fc_next", 256'(if0.frame_cnt), 256'(4));
      chk("s5.err_sticky", 256'(if0.cnt_err), 256'(1));

      // Scenario 6: scenario 1 with clk_en toggling, then an out-of-range cnt.
      do_reset();
      sel = '0;
      scen1(1'b1);
      chk("s6.err_clean", 256'(if0.cnt_err), 256'(0));
      step(30, 'h155, 1'b1);
      chk("s6.cnt_err", 256'(if0.cnt_err), 256'(1));
      chk("s6.no_done", 256'(if0.frame_done), 256'(0));

      // Randomized run: glitches, gaps, resets, mask/sel churn.
      cur = 0;
      for (int i = 0; i < 4000; i++) begin
         logic en;
         en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 399) == 0) rst = 1'b1;
         if ($urandom_range(0, 63) == 0) sel = CW'($urandom_range(0, 27));
         mask = N'($urandom);
         if (en) begin
            if ($urandom_range(0, 79) == 0) cur = int'($urandom_range(0, 31));
            else cur = (cur + 1) % N;
         end
         step(cur, ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 3))
                                              : int'($urandom_range(0, 1023)), en);
         rst = 1'b0;
      end

      chk_on = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
